// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR coefficient controller: state encoding and default sizing.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWAP  = 2'd2,
    FLUSH = 2'd3
  } fir_state_t;

  localparam int COEF_W       = 16;
  localparam int DEF_NUM_TAPS = 60;

  // The filter pipeline latency is NUM_TAPS+3, which is how long mixed results linger.
  function automatic int default_flush(input int num_taps);
    return num_taps + 3;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient storage: writes go to the shadow bank, reads come from the active one.
module fir_coef_bank #(
  parameter int NUM_TAPS   = 60,
  parameter int COEF_WIDTH = 16,
  parameter int IDX_WIDTH  = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [IDX_WIDTH-1:0]           idx,
  input  logic signed [COEF_WIDTH-1:0]   data,
  input  logic                           toggle,
  output logic                           bank_sel,
  output logic [NUM_TAPS*COEF_WIDTH-1:0] coef_bus
);

  logic [COEF_WIDTH-1:0] bank0 [NUM_TAPS];
  logic [COEF_WIDTH-1:0] bank1 [NUM_TAPS];

  // The shadow bank is always the one not currently selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
      bank_sel <= 1'b0;
    end else begin
      if (we && (idx < IDX_WIDTH'(NUM_TAPS))) begin
        if (bank_sel) bank0[idx] <= data;
        else          bank1[idx] <= data;
      end
      if (toggle) bank_sel <= ~bank_sel;
    end
  end

  always_comb begin
    coef_bus = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      coef_bus[i*COEF_WIDTH +: COEF_WIDTH] = bank_sel ? bank1[i] : bank0[i];
    end
  end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Run-time coefficient controller: streams a shadow bank, swaps it in atomically, then
// masks the filter output until the pipeline no longer holds mixed-coefficient samples.
module fir_coef_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int NUM_TAPS     = DEF_NUM_TAPS,
  parameter int COEF_WIDTH   = COEF_W,
  parameter int FLUSH_CYCLES = default_flush(DEF_NUM_TAPS),
  parameter int IDX_WIDTH    = 6
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic                           i_coef_valid,
  input  logic signed [COEF_WIDTH-1:0]   i_coef_data,
  output logic                           o_coef_ready,
  output logic [NUM_TAPS*COEF_WIDTH-1:0] o_coef_bus,
  output logic                           o_filter_valid,
  output logic                           o_busy,
  output logic                           o_bank_sel,
  output logic                           o_load_done,
  output logic                           o_start_err
);

  localparam int CNT_WIDTH = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  fir_state_t           state, next_state;
  logic [IDX_WIDTH-1:0] idx;
  logic [CNT_WIDTH-1:0] flush_cnt;
  logic                 accept, last_word, swap_go, flush_end;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // Abort outranks a simultaneous handshake, so the word on the bus that cycle is dropped.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_start) next_state = LOAD;
      LOAD: begin
        if (i_abort)                  next_state = IDLE;
        else if (accept && last_word) next_state = SWAP;
      end
      SWAP:    next_state = FLUSH;
      FLUSH:   if (flush_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    accept    = (state == LOAD) && o_coef_ready && i_coef_valid && !i_abort;
    last_word = (idx == IDX_WIDTH'(NUM_TAPS - 1));
    swap_go   = (state == SWAP);
    flush_end = (state == FLUSH) && (flush_cnt == '0);
  end

  // Ready only rises once LOAD has been entered and falls as soon as LOAD is being left.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx            <= '0;
      flush_cnt      <= '0;
      o_coef_ready   <= 1'b0;
      o_filter_valid <= 1'b0;
      o_busy         <= 1'b0;
      o_load_done    <= 1'b0;
      o_start_err    <= 1'b0;
    end else begin
      if (state == IDLE && i_start) idx <= '0;
      else if (accept)              idx <= idx + IDX_WIDTH'(1);

      if (swap_go)                 flush_cnt <= CNT_WIDTH'(FLUSH_CYCLES - 1);
      else if (state == FLUSH && !flush_end) flush_cnt <= flush_cnt - CNT_WIDTH'(1);

      if (swap_go)        o_filter_valid <= 1'b0;
      else if (flush_end) o_filter_valid <= 1'b1;

      o_coef_ready <= (state == LOAD) && (next_state == LOAD);
      o_busy       <= (next_state != IDLE);
      o_load_done  <= flush_end;
      o_start_err  <= i_start && (state != IDLE);
    end
  end

  fir_coef_bank #(
    .NUM_TAPS  (NUM_TAPS),
    .COEF_WIDTH(COEF_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_bank (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .we      (accept),
    .idx     (idx),
    .data    (i_coef_data),
    .toggle  (swap_go),
    .bank_sel(o_bank_sel),
    .coef_bus(o_coef_bus)
  );

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Scoreboard bench for fir_coef_ctrl: completed loads push the expected bank, a monitor checks it on o_load_done.
module tb_fir_coef_ctrl;

  localparam int NT = 60;
  localparam int CW = 16;
  localparam int FC = 63;

  typedef struct packed {
    logic [NT*CW-1:0] bus;
    logic             sel;
  } exp_t;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic             i_abort = 1'b0;
  logic             i_coef_valid = 1'b0;
  logic [CW-1:0]    i_coef_data = '0;
  logic             o_coef_ready;
  logic [NT*CW-1:0] o_coef_bus;
  logic             o_filter_valid;
  logic             o_busy;
  logic             o_bank_sel;
  logic             o_load_done;
  logic             o_start_err;

  fir_coef_ctrl #(.NUM_TAPS(NT), .COEF_WIDTH(CW), .FLUSH_CYCLES(FC), .IDX_WIDTH(6)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_coef_valid  (i_coef_valid),
    .i_coef_data   (i_coef_data),
    .o_coef_ready  (o_coef_ready),
    .o_coef_bus    (o_coef_bus),
    .o_filter_valid(o_filter_valid),
    .o_busy        (o_busy),
    .o_bank_sel    (o_bank_sel),
    .o_load_done   (o_load_done),
    .o_start_err   (o_start_err)
  );

  always #5 i_clk = ~i_clk;

  int               n_checks = 0;
  int               n_fail = 0;
  int               seen_err = 0;
  int               exp_err = 0;
  logic [NT*CW-1:0] exp_active = '0;
  logic [NT*CW-1:0] exp_shadow = '0;
  logic             exp_sel = 1'b0;
  logic             exp_fv = 1'b0;
  exp_t             sb[$];
  exp_t             mon_e;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic checkBus(input string name, input logic [NT*CW-1:0] actual, input logic [NT*CW-1:0] expected);
    int bad = -1;
    n_checks++;
    for (int i = NT - 1; i >= 0; i--)
      if (actual[i*CW +: CW] !== expected[i*CW +: CW]) bad = i;
    if (bad >= 0) begin
      n_fail++;
      $display("[TB] FAIL %s: tap %0d actual=%h required=%h", name, bad,
               actual[bad*CW +: CW], expected[bad*CW +: CW]);
    end
  endtask

  // Monitor: every load completion must match the oldest outstanding expectation.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_load_done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_load_done: actual=1 required=0");
        end else begin
          mon_e = sb.pop_front();
          checkBus("done_bus", o_coef_bus, mon_e.bus);
          checkOutput("done_bank_sel", o_bank_sel, mon_e.sel);
          checkOutput("done_filter_valid", o_filter_valid, 1);
        end
      end
      if (o_start_err) seen_err++;
    end
  end

  // Runs one load session; returns early on abort (abort_at) or when wait_flush is 0.
  task automatic applyStimulus(input logic [CW-1:0] base, input int step, input int gap_pct,
                               input int abort_at, input int err_at, input bit wait_flush,
                               input int flush_err_at, input bit check_ready);
    int            guard;
    int            ready_cycles = 0;
    int            lowc = 0;
    logic          rdy;
    logic [CW-1:0] w;
    bit            gap;
    exp_t          e;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int k = 0; k < NT; k++) begin
      w = base + CW'(step * k);
      guard = 0;
      forever begin
        gap = (gap_pct > 0) && ($urandom_range(0, 99) < gap_pct);
        i_coef_valid = !gap;
        i_coef_data  = w;
        i_abort      = !gap && (k == abort_at);
        i_start      = !gap && (k == err_at);
        if (i_start) exp_err++;
        @(negedge i_clk);
        rdy = o_coef_ready;
        if (rdy) ready_cycles++;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        if (i_coef_valid && rdy) begin
          i_coef_valid = 1'b0;
          if (i_abort) begin
            i_abort = 1'b0;
            return;
          end
          exp_shadow[k*CW +: CW] = w;
          break;
        end
        guard++;
        if (guard > 200) begin
          i_coef_valid = 1'b0;
          checkOutput("handshake_timeout", guard, 0);
          return;
        end
      end
    end
    e.bus = exp_shadow;
    e.sel = ~exp_sel;
    sb.push_back(e);
    if (check_ready) checkOutput("ready_cycles", ready_cycles, NT);
    checkBus("bus_before_swap", o_coef_bus, exp_active);
    checkOutput("bank_sel_before_swap", o_bank_sel, exp_sel);
    exp_active = exp_shadow;
    exp_sel    = ~exp_sel;
    if (!wait_flush) return;
    @(posedge i_clk); #1;
    checkOutput("bank_sel_after_swap", o_bank_sel, exp_sel);
    checkBus("bus_after_swap", o_coef_bus, exp_active);
    checkOutput("filter_valid_after_swap", o_filter_valid, 0);
    while (lowc < 200) begin
      @(negedge i_clk);
      if (o_filter_valid) break;
      lowc++;
      if (lowc == flush_err_at) begin
        i_start = 1'b1;
        exp_err++;
      end else begin
        i_start = 1'b0;
      end
    end
    i_start = 1'b0;
    checkOutput("flush_low_cycles", lowc, FC);
    exp_fv = 1'b1;
    @(posedge i_clk); #1;
    checkOutput("busy_after_done", o_busy, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset and idle
    #23 i_rst_n = 1'b1;
    repeat (100) @(posedge i_clk);
    @(negedge i_clk);
    checkBus("reset_bus", o_coef_bus, exp_active);
    checkOutput("reset_filter_valid", o_filter_valid, 0);
    checkOutput("reset_busy", o_busy, 0);
    checkOutput("reset_bank_sel", o_bank_sel, 0);
    checkOutput("reset_ready", o_coef_ready, 0);
    @(posedge i_clk); #1;

    // Ramp load with valid held high
    applyStimulus(16'h0000, 1, 0, -1, -1, 1'b1, -1, 1'b1);
    checkOutput("tap59", o_coef_bus[59*CW +: CW], 16'h003B);

    // Constant 0x8000 load with idle gaps
    applyStimulus(16'h8000, 0, 30, -1, -1, 1'b1, -1, 1'b0);
    checkOutput("tap0_8000", o_coef_bus[0 +: CW], 16'h8000);

    // Abort together with the 21st word
    applyStimulus(16'h2000, 1, 0, 20, -1, 1'b0, -1, 1'b0);
    repeat (2) @(posedge i_clk); #1;
    checkOutput("abort_busy", o_busy, 0);
    checkOutput("abort_ready", o_coef_ready, 0);
    checkOutput("abort_bank_sel", o_bank_sel, exp_sel);
    checkOutput("abort_filter_valid", o_filter_valid, exp_fv);
    checkBus("abort_bus", o_coef_bus, exp_active);

    // Full load after abort, with stray starts in LOAD and FLUSH
    applyStimulus(16'h1000, 1, 0, -1, 5, 1'b1, 10, 1'b0);
    checkOutput("tap0_after_abort", o_coef_bus[0 +: CW], 16'h1000);

    // Asynchronous reset in the middle of FLUSH
    applyStimulus(16'h3000, 1, 0, -1, -1, 1'b0, -1, 1'b0);
    repeat (10) @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    #1;
    exp_active = '0;
    exp_shadow = '0;
    exp_sel    = 1'b0;
    exp_fv     = 1'b0;
    sb.delete();
    checkBus("async_reset_bus", o_coef_bus, exp_active);
    checkOutput("async_reset_filter_valid", o_filter_valid, 0);
    checkOutput("async_reset_busy", o_busy, 0);
    checkOutput("async_reset_bank_sel", o_bank_sel, 0);
    checkOutput("async_reset_load_done", o_load_done, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (100) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("post_reset_busy", o_busy, 0);
    checkOutput("post_reset_filter_valid", o_filter_valid, 0);

    checkOutput("start_err_count", seen_err, exp_err);
    checkOutput("pending_expectations", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_coef_ctrl.md
Name: fir_coef_ctrl

Overview:
Run-time coefficient controller for the parallel transposed FIR datapath.
- Accepts a coefficient stream over a valid/ready handshake into a shadow bank.
- Atomically swaps the shadow bank into the active bank that drives the filter's coefficient inputs.
- Holds a filter-output-valid qualifier low while the filter pipeline flushes samples computed with mixed coefficients.

Parameters:
- NUM_TAPS, 60, number of filter taps and coefficients per load.
- COEF_WIDTH, 16, signed coefficient width.
- FLUSH_CYCLES, 63, cycles o_filter_valid stays low after a swap; equals filter latency NUM_TAPS+3.
- IDX_WIDTH, 6, width of the tap index counter; must satisfy 2^IDX_WIDTH >= NUM_TAPS.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  pulse that begins a load session.
- i_abort  in  1  abandons the current load session.
- i_coef_valid  in  1  coefficient word valid.
- i_coef_data  in  COEF_WIDTH  signed coefficient word.
- o_coef_ready  out  1  controller accepts a coefficient word.
- o_coef_bus  out  NUM_TAPS*COEF_WIDTH  active bank; tap i at bits [i*COEF_WIDTH +: COEF_WIDTH].
- o_filter_valid  out  1  filter output is trustworthy.
- o_busy  out  1  controller is not in IDLE.
- o_bank_sel  out  1  index of the active bank.
- o_load_done  out  1  one-cycle pulse when a load completes.
- o_start_err  out  1  one-cycle pulse when i_start arrives outside IDLE.

Behaviour:
- Reset (async assert, synchronous release):
  - state = IDLE; both banks all zero; o_bank_sel = 0; index = 0.
  - o_filter_valid = 0; o_coef_ready, o_busy, o_load_done, o_start_err all 0.
- o_filter_valid stays 0 after reset until the first completed load.
- IDLE:
  - o_coef_ready = 0.
  - i_start moves to LOAD and clears the index.
  - i_abort is ignored.
- LOAD:
  - o_coef_ready = 1 (registered; asserted from the cycle after entry).
  - On each i_coef_valid & o_coef_ready, i_coef_data is written to shadow[index] and index increments.
  - The first accepted word goes to tap 0.
  - Accepting the word at index NUM_TAPS-1 moves to SWAP.
  - i_abort moves to IDLE; o_coef_ready drops the next cycle.
  - On abort, the shadow contents are don't-care, the active bank is unchanged and o_filter_valid is unchanged.
  - Abort in the same cycle as a handshake: abort wins and the word is discarded. The source must not count that word as accepted; since o_coef_ready was high, the bench treats a word presented with i_abort as dropped.
- SWAP (1 cycle):
  - o_bank_sel toggles; o_coef_bus reflects the new bank from the next edge.
  - o_filter_valid <= 0; flush counter <= FLUSH_CYCLES-1.
  - Next state FLUSH.
- FLUSH:
  - Counter decrements each cycle.
  - When the counter reaches 0: state IDLE, o_filter_valid <= 1, o_load_done pulses for 1 cycle.
  - i_abort is ignored (the swap is committed).
- i_start in LOAD, SWAP or FLUSH: ignored; o_start_err pulses the cycle after.
- o_busy = (state != IDLE), registered.
- Coefficient values pass through unmodified; there is no arithmetic on data.
- Index counter never wraps: the LOAD exit occurs at NUM_TAPS-1.
- Reset mid-LOAD or mid-FLUSH: everything returns to reset values, including zeroed banks.
- Total from the last accepted word to o_load_done is 1 (SWAP) + FLUSH_CYCLES cycles.

Decomposition:
- Package fir_ctrl_pkg holds:
  - state encoding constants (IDLE=2'd0, LOAD=2'd1, SWAP=2'd2, FLUSH=2'd3);
  - default FLUSH_CYCLES expression NUM_TAPS+3;
  - the bus slicing helper constant COEF_WIDTH.
- One sub-module, fir_coef_bank: two NUM_TAPS x COEF_WIDTH register banks with
  - a write port (we, index, data) targeting the non-selected bank;
  - a bank-select toggle;
  - the flattened output mux.
- FSM, counters and handshake stay in fir_coef_ctrl.

Test Plan:
- Reset then idle 100 cycles -> o_coef_bus all zero, o_filter_valid=0, o_busy=0, o_bank_sel=0.
- Start, stream 60 words 0x0000..0x003B with valid held high -> o_coef_ready high for 60 cycles; o_bank_sel=1 one cycle after the last word; o_filter_valid low for 63 cycles, then high; o_load_done pulses once; tap 59 slice = 0x003B.
- Second load of 0x8000 on every tap with random valid gaps (about 30% idle) -> bank flips back to 0, every slice = 0x8000, bus unchanged until the SWAP edge, o_filter_valid re-asserts 63 cycles after SWAP.
- Start, 20 words, assert i_abort together with word 21 -> state IDLE, o_coef_bus and o_bank_sel unchanged; a subsequent full load writes tap 0 first (index restarted).
- i_start pulsed during LOAD and during FLUSH -> o_start_err pulses once each; load completes normally with the correct data.
- Assert i_rst_n low asynchronously mid-FLUSH (between edges) -> outputs reach reset values immediately without waiting for a clock edge; o_filter_valid=0, banks zero.
